// File: rtl/uart_pkg.sv
// Shared UART types and constants for the byte-stream bridge.
package uart_pkg;

    localparam logic [31:0] UART_EMPTY_WORD = 32'hFFFF_FFFF;

    typedef logic [7:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/uart_fifo_bridge_if.sv
// Core-side byte-stream handshake between peripheral logic and the UART bridge.
interface uart_fifo_bridge_if
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic            tx_valid;
    logic            tx_ready;
    uart_byte_t      tx_data;
    logic            rx_valid;
    logic            rx_ready;
    uart_byte_t      rx_data;
    logic [LW-1:0]   tx_level;
    logic [LW-1:0]   rx_level;
    logic            tx_idle;

    modport master (
        output tx_valid, tx_data, rx_ready,
        input  tx_ready, rx_valid, rx_data, tx_level, rx_level, tx_idle
    );

    modport slave (
        input  tx_valid, tx_data, rx_ready,
        output tx_ready, rx_valid, rx_data, tx_level, rx_level, tx_idle
    );

endinterface : uart_fifo_bridge_if

// File: rtl/uart_byte_fifo.sv
// Register-based byte FIFO with combinational head read and an explicit level counter.
// A push into a full FIFO or a pop from an empty one is ignored.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  uart_byte_t               din,
    input  logic                     pop,
    output uart_byte_t               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    uart_byte_t       mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW-1:0]    wr_q, wr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    // Pointer/level next state; pointers wrap naturally at DEPTH.
    always_comb begin
        full    = (level_q == LW'(DEPTH));
        empty   = (level_q == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        rd_d    = rd_q;
        wr_d    = wr_q;
        level_d = level_q;
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            level_q <= level_d;
            if (do_push) mem_q[wr_q] <= din;
        end
    end

    // Stale storage is masked so an empty FIFO always presents zero.
    assign dout  = empty ? '0 : mem_q[rd_q];
    assign level = level_q;

endmodule : uart_byte_fifo

// File: rtl/uart_fifo_bridge.sv
// Buffered front end for the UART data register: TX FIFO feeds the UART when it
// is not busy, RX FIFO drains the UART's single-byte buffer as soon as it fills.
module uart_fifo_bridge
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    uart_fifo_bridge_if.slave    bus,
    output logic                 uart_dat_we,
    output logic [31:0]          uart_dat_di,
    input  logic                 uart_dat_wait,
    output logic                 uart_dat_re,
    input  logic [31:0]          uart_dat_do
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic          tx_full, tx_empty;
    logic          rx_full, rx_empty;
    uart_byte_t    tx_head;
    logic [LW-1:0] tx_level, rx_level;
    logic          rx_byte_present;
    logic          rx_pop;
    logic          unused_do;

    uart_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (bus.tx_valid),
        .din    (bus.tx_data),
        .pop    (uart_dat_we),
        .dout   (tx_head),
        .full   (tx_full),
        .empty  (tx_empty),
        .level  (tx_level)
    );

    uart_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (uart_dat_re),
        .din    (uart_dat_do[7:0]),
        .pop    (rx_pop),
        .dout   (bus.rx_data),
        .full   (rx_full),
        .empty  (rx_empty),
        .level  (rx_level)
    );

    // The UART raises wait the cycle after a write, so we can never fire twice in a row.
    assign uart_dat_we     = !tx_empty && !uart_dat_wait;
    assign uart_dat_di     = {24'h0, tx_head};
    assign bus.tx_ready    = !tx_full;
    assign bus.tx_level    = tx_level;
    assign bus.tx_idle     = tx_empty && !uart_dat_wait;

    // Bit 31 clear marks a byte waiting in the UART; leave it there while RX is full.
    assign rx_byte_present = !uart_dat_do[31];
    assign uart_dat_re     = rx_byte_present && !rx_full;
    assign bus.rx_valid    = !rx_empty;
    assign bus.rx_level    = rx_level;
    assign rx_pop          = !rx_empty && bus.rx_ready;

    assign unused_do       = ^uart_dat_do[30:8];

endmodule : uart_fifo_bridge

// File: doc/uart_fifo_bridge.md
# uart_fifo_bridge

Buffered byte-stream front end for the on-chip UART. It sits between the core-side peripheral logic and the UART data register port. A TX FIFO absorbs bursts of bytes and feeds the UART only when it is not busy. An RX FIFO drains received bytes from the UART's single-byte buffer as soon as they appear, so software polling latency no longer causes overruns.

## Interface
- DEPTH, 8: entries per FIFO; power of two, ≥2.
- LW, $clog2(DEPTH)+1: level counter width (derived, not overridable).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- tx_valid  in  1  upstream byte offered
- tx_ready  out  1  TX FIFO not full
- tx_data  in  8  byte to transmit
- rx_valid  out  1  RX FIFO not empty
- rx_ready  in  1  upstream consumes head byte
- rx_data  out  8  RX FIFO head byte
- tx_level  out  LW  TX FIFO occupancy
- rx_level  out  LW  RX FIFO occupancy
- tx_idle  out  1  TX FIFO empty and uart_dat_wait low
- uart_dat_we  out  1  write strobe to UART data register
- uart_dat_di  out  32  {24'h0, TX head byte}
- uart_dat_wait  in  1  UART transmitter busy (includes post-divider-change idle frame)
- uart_dat_re  out  1  read strobe to UART data register
- uart_dat_do  in  32  UART read data: 32'hFFFF_FFFF = empty; otherwise {24'h0, byte}

## Operation
- TX push: tx_valid && tx_ready. tx_ready = !tx_full.
- TX pop: uart_dat_we = !tx_empty && !uart_dat_wait. This is combinational from registered FIFO state and uart_dat_wait. The pop happens in the same cycle as uart_dat_we.
- The UART raises uart_dat_wait the cycle after an accepted write. No extra guard cycle is needed, and back-to-back we is impossible by construction.
- RX byte-present: uart_dat_do[31] == 0.
- RX pop from UART: uart_dat_re = byte-present && !rx_full. In the same cycle, uart_dat_do[7:0] is pushed into the RX FIFO.
- RX FIFO full: re is held low and the byte stays in the UART. A later UART overwrite is the UART's overrun, not detected here.
- RX consume: rx_valid && rx_ready pops the head. rx_data is valid whenever rx_valid is high.
- Each FIFO keeps a read pointer, a write pointer (log2(DEPTH) bits, natural wrap) and a level counter (LW bits).
- Level update per cycle: +1 for push only, −1 for pop only, unchanged for simultaneous push and pop.
- Simultaneous push and pop is legal at any level where both are enabled: a full FIFO pops and refuses the push; an empty FIFO pushes only.
- Full = level == DEPTH. Empty = level == 0.
- No bytes are reordered, duplicated or dropped inside the bridge.

## Timing
- Reset (resetn low at posedge) clears pointers and levels.
- Post-reset outputs: tx_ready=1, rx_valid=0, tx_level=0, rx_level=0, uart_dat_we=0, uart_dat_re=0, uart_dat_di=0, rx_data=0.
- tx_idle follows uart_dat_wait after reset.
- Reset mid-operation discards all buffered bytes in both FIFOs. A UART frame already in flight is not the bridge's concern.
- TX latency: a byte pushed at cycle t is eligible for uart_dat_we at t+1, provided uart_dat_wait is low.
- RX latency: a byte present at the UART at cycle t (RX not full) gives uart_dat_re at t and rx_valid/rx_data at t+1.
- The UART clears its buffer at t+1, so re deasserts at t+1 unless a new byte has already landed.
- FIFO storage is register-based. Read data is the combinational head of the array, with no read-latency cycle.

## Structure
- Shared package uart_pkg:
  - UART_EMPTY_WORD = 32'hFFFF_FFFF
  - typedef uart_byte_t = logic [7:0]
- Sub-module uart_byte_fifo (parameter DEPTH):
  - ports: clk, resetn, push, din, pop, dout, full, empty, level.
  - instantiated twice, for TX and RX.
- The top level contains only the handshake glue above.

## Test plan
- TX burst: push 0x41, 0x42, 0x43 on consecutive cycles with uart_dat_wait low → tx_level reaches 2 (pop overlaps push). uart_dat_we fires once per wait-low window with di = 0x41, 0x42, 0x43 in order. tx_idle=1 after the last frame.
- TX full: push DEPTH bytes while wait is held high → tx_ready=0, tx_level=DEPTH. A further tx_valid is ignored. On the first wait-low cycle, we fires and tx_ready returns to 1 the next cycle.
- RX drain: UART presents 0x000000A5 → uart_dat_re at the same cycle, rx_valid=1 and rx_data=0xA5 the next cycle, rx_level=1. A subsequent do=0xFFFFFFFF produces no re.
- RX full: rx_ready=0 with DEPTH bytes received → rx_level=DEPTH and re stays low while do holds 0x0000005A. A single rx_ready pulse causes re on the following cycle and 0x5A enters the FIFO.
- Wrap/simultaneous: at RX level 1, push and pop in the same cycle for 2×DEPTH cycles → level stays 1 and data order is preserved across pointer wrap.
- Reset mid-burst: assert resetn=0 with both FIFOs half full → next cycle both levels are 0, tx_ready=1, rx_valid=0, uart_dat_we=0.
